// File: rtl/burst_bus_pkg.sv
// Shared types and constants for the burst bus master and its address generator.
package burst_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DIR     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_WRAP    = 2'd3;

   function automatic logic is_pow2(input logic [31:0] n);
      return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational next-beat address: plain increment, or increment confined to an
// aligned window of (beats_minus_one + 1) words for wrapping bursts.
module burst_addr_gen #(
   parameter int ADDR_W = 4,
   parameter int LEN_W  = 4
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  beats_minus_one,
   input  logic              wrap,
   output logic [ADDR_W-1:0] next_addr
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] mask;
   logic [ADDR_W-1:0] inc;

   // A power-of-two beat count minus one is exactly the in-window offset mask.
   generate
      if (LEN_W >= ADDR_W) begin : g_mask_trunc
         assign mask = beats_minus_one[ADDR_W-1:0];
      end else begin : g_mask_ext
         assign mask = {{(ADDR_W-LEN_W){1'b0}}, beats_minus_one};
      end
   endgenerate

   always_comb begin
      inc       = addr + ADDR_ONE;
      next_addr = inc;
      if (wrap) begin
         next_addr = (addr & ~mask) | (inc & mask);
      end
   end

endmodule

// File: rtl/burst_bus_master.sv
// Single-command burst master on a valid/ready slave bus, with write-data fetch,
// wrapping bursts, per-beat timeout and error reporting.
module burst_bus_master
   import burst_bus_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_wr,
   input  logic              io_rd,
   input  logic              io_wrap,
   input  logic [ADDR_W-1:0] io_address,
   input  logic [LEN_W-1:0]  io_length,
   input  logic [DATA_W-1:0] io_wdata,
   input  logic              io_wdata_valid,
   output logic              io_wdata_ready,
   output logic [DATA_W-1:0] io_rdata,
   output logic              io_rdata_valid,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_error,
   output logic [1:0]        io_err_code,
   output logic              bus_valid,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_address,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

   state_t            state;
   logic [LEN_W-1:0]  len_m1;
   logic [LEN_W-1:0]  beats_left;
   logic              wrap_mode;
   logic [WAIT_W-1:0] wait_cnt;
   logic [ADDR_W-1:0] next_addr;

   burst_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .addr            (bus_address),
      .beats_minus_one (len_m1),
      .wrap            (wrap_mode),
      .next_addr       (next_addr)
   );

   // beats_left holds remaining beats minus one, so zero marks the final beat.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         len_m1         <= '0;
         beats_left     <= '0;
         wrap_mode      <= 1'b0;
         wait_cnt       <= '0;
         io_wdata_ready <= 1'b0;
         io_rdata       <= '0;
         io_rdata_valid <= 1'b0;
         io_busy        <= 1'b0;
         io_done        <= 1'b0;
         io_error       <= 1'b0;
         io_err_code    <= ERR_NONE;
         bus_valid      <= 1'b0;
         bus_wr         <= 1'b0;
         bus_address    <= '0;
         bus_wdata      <= '0;
      end else begin
         io_done        <= 1'b0;
         io_error       <= 1'b0;
         io_err_code    <= ERR_NONE;
         io_rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (io_start) begin
                  if (io_wr == io_rd) begin
                     io_error    <= 1'b1;
                     io_err_code <= ERR_DIR;
                  end else if (io_wrap && !is_pow2(32'(io_length) + 32'd1)) begin
                     io_error    <= 1'b1;
                     io_err_code <= ERR_WRAP;
                  end else begin
                     bus_wr      <= io_wr;
                     bus_address <= io_address;
                     len_m1      <= io_length;
                     beats_left  <= io_length;
                     wrap_mode   <= io_wrap;
                     wait_cnt    <= '0;
                     io_busy     <= 1'b1;
                     if (io_wr) begin
                        io_wdata_ready <= 1'b1;
                        state          <= FETCH;
                     end else begin
                        bus_valid <= 1'b1;
                        state     <= XFER;
                     end
                  end
               end
            end
            FETCH: begin
               if (io_wdata_valid) begin
                  bus_wdata      <= io_wdata;
                  io_wdata_ready <= 1'b0;
                  bus_valid      <= 1'b1;
                  state          <= XFER;
               end
            end
            XFER: begin
               if (bus_ready) begin
                  wait_cnt    <= '0;
                  bus_address <= next_addr;
                  if (!bus_wr) begin
                     io_rdata       <= bus_rdata;
                     io_rdata_valid <= 1'b1;
                  end
                  if (beats_left == '0) begin
                     bus_valid <= 1'b0;
                     io_busy   <= 1'b0;
                     io_done   <= 1'b1;
                     state     <= DONE;
                  end else begin
                     beats_left <= beats_left - LEN_ONE;
                     if (bus_wr) begin
                        bus_valid      <= 1'b0;
                        io_wdata_ready <= 1'b1;
                        state          <= FETCH;
                     end
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  wait_cnt    <= '0;
                  bus_valid   <= 1'b0;
                  io_busy     <= 1'b0;
                  io_done     <= 1'b1;
                  io_error    <= 1'b1;
                  io_err_code <= ERR_TIMEOUT;
                  state       <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_ONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_bus_master.sv
// Directed self-checking bench for burst_bus_master; the slave model returns
// address * 0x11 as read data.
module tb_burst_bus_master;

   logic        clock;
   logic        reset;
   logic        io_start;
   logic        io_wr;
   logic        io_rd;
   logic        io_wrap;
   logic [3:0]  io_address;
   logic [3:0]  io_length;
   logic [31:0] io_wdata;
   logic        io_wdata_valid;
   logic        io_wdata_ready;
   logic [31:0] io_rdata;
   logic        io_rdata_valid;
   logic        io_busy;
   logic        io_done;
   logic        io_error;
   logic [1:0]  io_err_code;
   logic        bus_valid;
   logic        bus_wr;
   logic [3:0]  bus_address;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int checks = 0;
   int passed = 0;

   burst_bus_master #(
      .ADDR_W  (4),
      .DATA_W  (32),
      .LEN_W   (4),
      .TIMEOUT (15)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .io_start       (io_start),
      .io_wr          (io_wr),
      .io_rd          (io_rd),
      .io_wrap        (io_wrap),
      .io_address     (io_address),
      .io_length      (io_length),
      .io_wdata       (io_wdata),
      .io_wdata_valid (io_wdata_valid),
      .io_wdata_ready (io_wdata_ready),
      .io_rdata       (io_rdata),
      .io_rdata_valid (io_rdata_valid),
      .io_busy        (io_busy),
      .io_done        (io_done),
      .io_error       (io_error),
      .io_err_code    (io_err_code),
      .bus_valid      (bus_valid),
      .bus_wr         (bus_wr),
      .bus_address    (bus_address),
      .bus_wdata      (bus_wdata),
      .bus_ready      (bus_ready),
      .bus_rdata      (bus_rdata)
   );

   assign bus_rdata = 32'(bus_address) * 32'h11;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed %0b, expected %0b", tag, obs, exp);
   endtask

   task automatic apply_stimulus(input logic wr, input logic rd, input logic wrap,
                                 input logic [3:0] addr, input logic [3:0] len);
      io_start   = 1'b1;
      io_wr      = wr;
      io_rd      = rd;
      io_wrap    = wrap;
      io_address = addr;
      io_length  = len;
      tick();
      io_start   = 1'b0;
      io_wr      = 1'b0;
      io_rd      = 1'b0;
      io_wrap    = 1'b0;
   endtask

   // Entered in a FETCH cycle with bus_ready=1; leaves in the cycle after XFER.
   task automatic write_beat(input logic [31:0] data, input int gap, input logic [3:0] exp_addr);
      io_wdata_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         check_bit("wr_gap_ready", io_wdata_ready, 1'b1);
         check_bit("wr_gap_valid", bus_valid, 1'b0);
         tick();
      end
      check_bit("wr_fetch_ready", io_wdata_ready, 1'b1);
      io_wdata       = data;
      io_wdata_valid = 1'b1;
      tick();
      io_wdata_valid = 1'b0;
      check_bit("wr_xfer_valid", bus_valid, 1'b1);
      check_bit("wr_xfer_ready_low", io_wdata_ready, 1'b0);
      check_word("wr_xfer_addr", 32'(bus_address), 32'(exp_addr));
      check_word("wr_xfer_data", bus_wdata, data);
      tick();
   endtask

   initial begin
      reset          = 1'b1;
      io_start       = 1'b0;
      io_wr          = 1'b0;
      io_rd          = 1'b0;
      io_wrap        = 1'b0;
      io_address     = '0;
      io_length      = '0;
      io_wdata       = '0;
      io_wdata_valid = 1'b0;
      bus_ready      = 1'b0;
      #2 reset = 1'b0;
      tick();
      tick();
      check_bit("rst_busy", io_busy, 1'b0);
      check_bit("rst_valid", bus_valid, 1'b0);
      check_bit("rst_done", io_done, 1'b0);
      check_word("rst_addr", 32'(bus_address), 32'd0);
      check_word("rst_wdata", bus_wdata, 32'd0);
      check_word("rst_rdata", io_rdata, 32'd0);
      reset = 1'b1;
      tick();

      $display("[TB] single write with delayed ready");
      io_wdata       = 32'hA;
      io_wdata_valid = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 4'd6, 4'd0);
      check_bit("w1_fetch_ready", io_wdata_ready, 1'b1);
      check_bit("w1_fetch_busy", io_busy, 1'b1);
      check_bit("w1_fetch_valid", bus_valid, 1'b0);
      tick();
      io_wdata_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_bit("w1_hold_valid", bus_valid, 1'b1);
         check_bit("w1_hold_wr", bus_wr, 1'b1);
         check_word("w1_hold_addr", 32'(bus_address), 32'd6);
         check_word("w1_hold_data", bus_wdata, 32'hA);
         check_bit("w1_hold_nodone", io_done, 1'b0);
         bus_ready = (i == 3);
         tick();
      end
      bus_ready = 1'b0;
      check_bit("w1_done", io_done, 1'b1);
      check_bit("w1_noerr", io_error, 1'b0);
      check_bit("w1_busy_in_done", io_busy, 1'b0);
      check_bit("w1_valid_drop", bus_valid, 1'b0);
      tick();
      check_bit("w1_done_pulse", io_done, 1'b0);

      $display("[TB] incrementing read");
      bus_ready = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd7, 4'd3);
      for (int i = 0; i < 4; i++) begin
         check_bit("r2_valid", bus_valid, 1'b1);
         check_bit("r2_dir", bus_wr, 1'b0);
         check_word("r2_addr", 32'(bus_address), 32'(7 + i));
         check_bit("r2_rvalid", io_rdata_valid, (i > 0));
         if (i > 0) check_word("r2_rdata", io_rdata, 32'((6 + i) * 32'h11));
         tick();
      end
      bus_ready = 1'b0;
      check_bit("r2_done", io_done, 1'b1);
      check_bit("r2_last_rvalid", io_rdata_valid, 1'b1);
      check_word("r2_last_rdata", io_rdata, 32'hAA);
      check_bit("r2_valid_drop", bus_valid, 1'b0);
      tick();
      check_bit("r2_rvalid_pulse", io_rdata_valid, 1'b0);

      $display("[TB] wrapping write");
      bus_ready = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b1, 4'd6, 4'd3);
      write_beat(32'hC, 0, 4'd6);
      write_beat(32'hD, 2, 4'd7);
      write_beat(32'hE, 0, 4'd4);
      write_beat(32'hF, 0, 4'd5);
      bus_ready = 1'b0;
      check_bit("w3_done", io_done, 1'b1);
      check_bit("w3_noerr", io_error, 1'b0);
      check_bit("w3_ready_low", io_wdata_ready, 1'b0);
      tick();

      $display("[TB] timeout");
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2, 4'd1);
      for (int i = 0; i < 15; i++) begin
         check_bit("t4_valid_held", bus_valid, 1'b1);
         check_bit("t4_nodone", io_done, 1'b0);
         tick();
      end
      check_bit("t4_valid_drop", bus_valid, 1'b0);
      check_bit("t4_done", io_done, 1'b1);
      check_bit("t4_error", io_error, 1'b1);
      check_word("t4_code", 32'(io_err_code), 32'd2);
      check_bit("t4_busy_done", io_busy, 1'b0);
      tick();
      check_bit("t4_busy_after", io_busy, 1'b0);
      check_bit("t4_error_pulse", io_error, 1'b0);
      check_word("t4_code_clear", 32'(io_err_code), 32'd0);

      $display("[TB] rejected commands");
      apply_stimulus(1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
      check_bit("e5_dir_error", io_error, 1'b1);
      check_word("e5_dir_code", 32'(io_err_code), 32'd1);
      check_bit("e5_dir_busy", io_busy, 1'b0);
      check_bit("e5_dir_nodone", io_done, 1'b0);
      tick();
      check_bit("e5_dir_pulse", io_error, 1'b0);
      check_bit("e5_dir_still_idle", io_busy, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b1, 4'd4, 4'd2);
      check_bit("e5_wrap_error", io_error, 1'b1);
      check_word("e5_wrap_code", 32'(io_err_code), 32'd3);
      check_bit("e5_wrap_busy", io_busy, 1'b0);
      tick();
      check_bit("e5_wrap_fetch", io_wdata_ready, 1'b0);

      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
      check_word("e5_busy_addr0", 32'(bus_address), 32'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 4'd9, 4'd0);
      check_bit("e5_busy_noerr", io_error, 1'b0);
      check_bit("e5_busy_dir", bus_wr, 1'b0);
      check_word("e5_busy_addr", 32'(bus_address), 32'd0);
      check_bit("e5_busy_valid", bus_valid, 1'b1);
      bus_ready = 1'b1;
      tick();
      check_word("e5_busy_beat2", 32'(bus_address), 32'd1);
      check_word("e5_busy_rdata0", io_rdata, 32'h00);
      tick();
      bus_ready = 1'b0;
      check_bit("e5_busy_done", io_done, 1'b1);
      check_word("e5_busy_rdata1", io_rdata, 32'h11);
      tick();

      $display("[TB] reset mid-burst");
      bus_ready = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd3, 4'd3);
      tick();
      check_word("x6_beat2_addr", 32'(bus_address), 32'd4);
      reset = 1'b0;
      #1;
      check_bit("x6_async_valid", bus_valid, 1'b0);
      check_bit("x6_async_busy", io_busy, 1'b0);
      check_word("x6_async_addr", 32'(bus_address), 32'd0);
      check_word("x6_async_rdata", io_rdata, 32'd0);
      check_bit("x6_async_rvalid", io_rdata_valid, 1'b0);
      tick();
      check_bit("x6_nodone_a", io_done, 1'b0);
      reset     = 1'b1;
      bus_ready = 1'b0;
      tick();
      check_bit("x6_nodone_b", io_done, 1'b0);
      check_bit("x6_idle_valid", bus_valid, 1'b0);
      bus_ready = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd5, 4'd0);
      check_bit("x6_next_valid", bus_valid, 1'b1);
      check_word("x6_next_addr", 32'(bus_address), 32'd5);
      tick();
      bus_ready = 1'b0;
      check_bit("x6_next_done", io_done, 1'b1);
      check_bit("x6_next_rvalid", io_rdata_valid, 1'b1);
      check_word("x6_next_rdata", io_rdata, 32'h55);
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/burst_bus_master.md
Name: burst_bus_master

Overview:
Parametrised successor to the two-FSM start/wr/rd/length master. It accepts one command (direction, start address, burst length, incr/wrap mode) and runs a multi-beat burst on a valid/ready slave bus. It streams write data in and read data out, one beat per handshake. It adds per-beat wait states, wrapping bursts, a bus timeout and error reporting. It sits between a command source (CPU or test FSM) and the interconnect slave port.

Parameters:
ADDR_W, 4, address width in beat (word) units
DATA_W, 32, data width
LEN_W, 4, width of length field; a burst carries length+1 beats, so 1..2^LEN_W beats
TIMEOUT, 15, max cycles bus_valid may wait for bus_ready before the burst aborts (>=1)

Ports:
clock  in  1  single clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
io_start  in  1  command strobe; sampled only in IDLE
io_wr  in  1  write command
io_rd  in  1  read command
io_wrap  in  1  1 = wrapping burst, 0 = incrementing
io_address  in  ADDR_W  start address
io_length  in  LEN_W  beats minus one
io_wdata  in  DATA_W  write beat data
io_wdata_valid  in  1  write beat available
io_wdata_ready  out  1  write beat consumed this cycle
io_rdata  out  DATA_W  read beat data (registered)
io_rdata_valid  out  1  one-cycle pulse per read beat
io_busy  out  1  command in progress
io_done  out  1  one-cycle pulse at end of command, normal or aborted
io_error  out  1  one-cycle pulse, coincident with io_done or with a rejected start
io_err_code  out  2  valid while io_error is high: 1 illegal dir, 2 timeout, 3 bad wrap length
bus_valid  out  1  beat request
bus_wr  out  1  beat direction
bus_address  out  ADDR_W  beat address
bus_wdata  out  DATA_W  beat write data
bus_ready  in  1  slave accepts or completes the beat
bus_rdata  in  DATA_W  read data, valid when bus_valid & bus_ready

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including io_rdata, bus_address and bus_wdata. Counters cleared. Asserting reset mid-burst drops bus_valid immediately, without waiting for a clock edge. No io_done is produced for the killed burst.
- States: IDLE, FETCH, XFER, DONE.
- IDLE, command accepted (io_start=1, io_wr xor io_rd = 1):
  - Latch direction, address, beats = length+1, wrap mode.
  - Go to FETCH for a write, XFER for a read. io_busy is 1 from the next cycle.
- IDLE, command rejected (no state change; pulse io_error for one cycle on the next cycle):
  - io_start with io_wr == io_rd: io_err_code = 1.
  - io_wrap=1 with a beat count that is not a power of two: io_err_code = 3.
- io_start while io_busy=1 is ignored.
- FETCH:
  - io_wdata_ready = 1.
  - On io_wdata_valid: register io_wdata into bus_wdata, go to XFER. Latency is 1 cycle per beat.
- XFER:
  - bus_valid = 1. bus_wr, bus_address and bus_wdata are held stable until handshake or abort.
  - Handshake is bus_valid & bus_ready in the same cycle.
  - Read beat: bus_rdata is registered to io_rdata, with io_rdata_valid pulsed the next cycle.
  - After each beat: decrement beats_left and advance the address. Next state is DONE after the last beat, otherwise FETCH (write) or XFER (read).
  - Back-to-back read beats with bus_ready held at 1 give one beat per cycle.
- Timeout:
  - A wait counter increments each XFER cycle with bus_ready=0 and clears on handshake.
  - When it reaches TIMEOUT, drop bus_valid and go to DONE with io_err_code = 2. Remaining beats are discarded.
- DONE: io_done = 1 for one cycle, plus io_error if the burst aborted. Then go to IDLE; io_busy is 0 in DONE.
- Address arithmetic:
  - Incrementing: addr + 1, modulo 2^ADDR_W (wraps at the top of the space silently).
  - Wrapping: mask = beats - 1; next = (addr & ~mask) | ((addr + 1) & mask).
  - Start address need not be aligned.
- Minimum latency:
  - Single write: start at cycle 0, FETCH cycle 1, XFER cycle 2 with bus_ready=1, io_done cycle 3.
  - Single read: io_done at cycle 2, io_rdata_valid at cycle 2.

Decomposition:
- Shared package burst_bus_pkg holds:
  - state enum (IDLE, FETCH, XFER, DONE);
  - err_code constants (ERR_NONE=0, ERR_DIR=1, ERR_TIMEOUT=2, ERR_WRAP=3);
  - helper is_pow2 for the beat count.
- One sub-module, burst_addr_gen: combinational next-address unit. Inputs are addr, beats_minus_one and wrap; output is next_addr, parametrised by ADDR_W and LEN_W.
- FSM, counters and data registers live in burst_bus_master.

Test Plan:
1. Single write: addr 6, len 0, wdata 0xA valid, bus_ready delayed 3 cycles. Expect bus_address 6 and bus_wdata 0xA held for 4 cycles, then one io_done, io_error 0.
2. Incrementing read: addr 7, len 3, bus_rdata = address*0x11, ready always 1. Expect addresses 7,8,9,10, io_rdata 0x77,0x88,0x99,0xAA on 4 consecutive pulses, then io_done.
3. Wrap write: addr 6, len 3, wrap=1, wdata C,D,E,F with a 2-cycle gap before D. Expect addresses 6,7,4,5, data C,D,E,F, io_wdata_ready only in FETCH cycles.
4. Timeout: read addr 2, len 1, bus_ready held 0. Expect bus_valid high for exactly 15 cycles, then io_done + io_error with code 2, and io_busy 0 after.
5. Rejects:
   - io_start with wr=rd=1: io_error with code 1, io_busy stays 0.
   - wrap with len 2: io_error with code 3.
   - io_start while busy: no effect on the running burst.
6. Reset mid-burst: 4-beat read, reset=0 during beat 2. Expect bus_valid 0 asynchronously, all outputs 0, no io_done. The next command runs normally.
